// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the pipeline register chain.
//   EXC_NONE  - exception code meaning "no exception"
//   TNEW_MAX  - largest Tnew representable in the default 2-bit field
//   slot_t    - fixed-width sideband of one slot (valid, regwrite, dst, pc, bd, exc).
//               The width-parameterised fields (tnew, payload) travel beside it in
//               pipe_slot, because a package typedef cannot follow module parameters.
//   sat_dec   - saturating decrement used for Tnew ageing (sat_dec(0) = 0)
//   merge_exc - earliest exception wins: an upstream code beats the feeding stage's code
package pipe_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam int         TNEW_MAX = 3;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [4:0]  dst;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
  } slot_t;

  function automatic int unsigned sat_dec(input int unsigned x);
    return (x == 32'd0) ? 32'd0 : x - 32'd1;
  endfunction

  function automatic logic [4:0] merge_exc(input logic [4:0] early, input logic [4:0] stage);
    return (early != EXC_NONE) ? early : stage;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one register slot of the pipeline chain.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   clear                 zero the whole slot (highest priority)
//   hold                  keep current contents
//   bubble                load a bubble: everything zero except pc/bd taken from src
//   src, src_tnew,        value presented by the previous slot (or the chain input);
//   src_payload           Tnew is aged by one cycle on load
//   q, q_tnew, q_payload  registered slot contents
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int TNEW_W    = 2,
  parameter int PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 hold,
  input  logic                 bubble,
  input  slot_t                src,
  input  logic [TNEW_W-1:0]    src_tnew,
  input  logic [PAYLOAD_W-1:0] src_payload,
  output slot_t                q,
  output logic [TNEW_W-1:0]    q_tnew,
  output logic [PAYLOAD_W-1:0] q_payload
);

  slot_t                ctrl_next_s;
  logic [TNEW_W-1:0]    tnew_next_s;
  logic [PAYLOAD_W-1:0] payload_next_s;

  // Next-slot select with priority clear > hold > bubble > load.
  always_comb begin
    ctrl_next_s    = q;
    tnew_next_s    = q_tnew;
    payload_next_s = q_payload;
    if (clear) begin
      ctrl_next_s    = '0;
      tnew_next_s    = '0;
      payload_next_s = '0;
    end else if (hold) begin
      ctrl_next_s    = q;
      tnew_next_s    = q_tnew;
      payload_next_s = q_payload;
    end else if (bubble) begin
      // pc/bd survive so CP0 records a correct EPC/BD if an interrupt lands on the bubble.
      ctrl_next_s     = '0;
      ctrl_next_s.pc  = src.pc;
      ctrl_next_s.bd  = src.bd;
      tnew_next_s     = '0;
      payload_next_s  = '0;
    end else begin
      ctrl_next_s    = src;
      tnew_next_s    = TNEW_W'(sat_dec(32'(src_tnew)));
      payload_next_s = src_payload;
    end
  end

  // Slot storage register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q         <= '0;
      q_tnew    <= '0;
      q_payload <= '0;
    end else begin
      q         <= ctrl_next_s;
      q_tnew    <= tnew_next_s;
      q_payload <= payload_next_s;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-slot register chain between two pipeline stages, carrying a
// payload plus hazard/exception sideband. Latency in->out is DEPTH cycles when not stalled.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset (clears all slots)
//   req                        exception/interrupt: clear all slots (beats stall)
//   stall                      hold every slot
//   flush                      bubble into slot 0, later slots advance
//   in_*                       instruction entering slot 0; stage_exc_code merged into exc
//   out_*                      contents of the last slot (pure register reads)
//   hz_regwrite/hz_dst/hz_tnew per-slot hazard view, slot k at index k
//   perf_stall_cnt/perf_bubble_cnt  saturating event counters
// Build option: define STAGE_PERF_CNT_EN to include the performance counters; when it is
// undefined both counter ports are tied to zero.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DEPTH     = 1,
  parameter int PAYLOAD_W = 64,
  parameter int TNEW_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic                      in_regwrite,
  input  logic [4:0]                in_dst,
  input  logic [TNEW_W-1:0]         in_tnew,
  input  logic [31:0]               in_pc,
  input  logic                      in_bd,
  input  logic [4:0]                in_exc_code,
  input  logic [4:0]                stage_exc_code,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  output logic                      out_valid,
  output logic                      out_regwrite,
  output logic [4:0]                out_dst,
  output logic [TNEW_W-1:0]         out_tnew,
  output logic [31:0]               out_pc,
  output logic                      out_bd,
  output logic [4:0]                out_exc_code,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [DEPTH-1:0]          hz_regwrite,
  output logic [5*DEPTH-1:0]        hz_dst,
  output logic [TNEW_W*DEPTH-1:0]   hz_tnew,
  output logic [31:0]               perf_stall_cnt,
  output logic [31:0]               perf_bubble_cnt
);

  slot_t                slot_r    [DEPTH];
  logic [TNEW_W-1:0]    tnew_r    [DEPTH];
  logic [PAYLOAD_W-1:0] payload_r [DEPTH];
  slot_t                in_slot_s;

  // Pack the chain input into slot form with the exception codes merged.
  always_comb begin
    in_slot_s          = '0;
    in_slot_s.valid    = in_valid;
    in_slot_s.regwrite = in_regwrite;
    in_slot_s.dst      = in_dst;
    in_slot_s.pc       = in_pc;
    in_slot_s.bd       = in_bd;
    in_slot_s.exc      = merge_exc(in_exc_code, stage_exc_code);
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    slot_t                src_s;
    logic [TNEW_W-1:0]    src_tnew_s;
    logic [PAYLOAD_W-1:0] src_payload_s;
    logic                 bubble_s;

    if (k == 0) begin : g_head
      // A non-valid input is loaded exactly like a flush bubble.
      assign src_s         = in_slot_s;
      assign src_tnew_s    = in_tnew;
      assign src_payload_s = in_payload;
      assign bubble_s      = flush | ~in_valid;
    end else begin : g_tail
      assign src_s         = slot_r[k-1];
      assign src_tnew_s    = tnew_r[k-1];
      assign src_payload_s = payload_r[k-1];
      assign bubble_s      = 1'b0;
    end

    pipe_slot #(
      .TNEW_W   (TNEW_W),
      .PAYLOAD_W(PAYLOAD_W)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .clear      (req),
      .hold       (stall),
      .bubble     (bubble_s),
      .src        (src_s),
      .src_tnew   (src_tnew_s),
      .src_payload(src_payload_s),
      .q          (slot_r[k]),
      .q_tnew     (tnew_r[k]),
      .q_payload  (payload_r[k])
    );

    assign hz_regwrite[k]               = slot_r[k].valid & slot_r[k].regwrite;
    assign hz_dst[5*k +: 5]             = slot_r[k].dst;
    assign hz_tnew[TNEW_W*k +: TNEW_W]  = tnew_r[k];
  end

  assign out_valid    = slot_r[DEPTH-1].valid;
  assign out_regwrite = slot_r[DEPTH-1].regwrite;
  assign out_dst      = slot_r[DEPTH-1].dst;
  assign out_tnew     = tnew_r[DEPTH-1];
  assign out_pc       = slot_r[DEPTH-1].pc;
  assign out_bd       = slot_r[DEPTH-1].bd;
  assign out_exc_code = slot_r[DEPTH-1].exc;
  assign out_payload  = payload_r[DEPTH-1];

`ifdef STAGE_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] bubble_cnt_r;

  // Saturating stall and bubble counters; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r  <= 32'd0;
      bubble_cnt_r <= 32'd0;
    end else begin
      if (stall && !req && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (!req && !stall && (flush || !in_valid) && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
        bubble_cnt_r <= bubble_cnt_r + 32'd1;
      end
    end
  end

  assign perf_stall_cnt  = stall_cnt_r;
  assign perf_bubble_cnt = bubble_cnt_r;
`else
  assign perf_stall_cnt  = 32'd0;
  assign perf_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: scoreboard bench for pipe_stage_chain with DEPTH=3.
// The stimulus process updates a reference model of in-flight instructions at every
// clock edge and queues the expected visible state; a monitor pops and compares it
// shortly after each edge. Directed scenarios are followed by a randomized run.
module tb_pipe_stage_chain;

  localparam int DEPTH = 3;
  localparam int PW    = 64;
  localparam int TW    = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req = 1'b0, stall = 1'b0, flush = 1'b0;
  logic            in_valid = 1'b0, in_regwrite = 1'b0, in_bd = 1'b0;
  logic [4:0]      in_dst = 5'd0, in_exc_code = 5'd0, stage_exc_code = 5'd0;
  logic [TW-1:0]   in_tnew = '0;
  logic [31:0]     in_pc = 32'd0;
  logic [PW-1:0]   in_payload = '0;

  logic            out_valid, out_regwrite, out_bd;
  logic [4:0]      out_dst, out_exc_code;
  logic [TW-1:0]   out_tnew;
  logic [31:0]     out_pc, perf_stall_cnt, perf_bubble_cnt;
  logic [PW-1:0]   out_payload;
  logic [DEPTH-1:0]    hz_regwrite;
  logic [5*DEPTH-1:0]  hz_dst;
  logic [TW*DEPTH-1:0] hz_tnew;

  pipe_stage_chain #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .TNEW_W(TW)) dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regwrite(in_regwrite), .in_dst(in_dst), .in_tnew(in_tnew),
    .in_pc(in_pc), .in_bd(in_bd), .in_exc_code(in_exc_code), .stage_exc_code(stage_exc_code),
    .in_payload(in_payload),
    .out_valid(out_valid), .out_regwrite(out_regwrite), .out_dst(out_dst), .out_tnew(out_tnew),
    .out_pc(out_pc), .out_bd(out_bd), .out_exc_code(out_exc_code), .out_payload(out_payload),
    .hz_regwrite(hz_regwrite), .hz_dst(hz_dst), .hz_tnew(hz_tnew),
    .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // One in-flight instruction as the spec describes it; tn is the Tnew it entered with.
  typedef struct {
    bit v; bit rw; logic [4:0] dst; int tn; logic [31:0] pc; bit bd; logic [4:0] exc; logic [PW-1:0] pl;
  } ent_t;

  typedef struct {
    logic v; logic rw; logic [4:0] dst; logic [TW-1:0] tn; logic [31:0] pc; logic bd;
    logic [4:0] exc; logic [PW-1:0] pl; logic [DEPTH-1:0] hrw; logic [5*DEPTH-1:0] hdst;
    logic [TW*DEPTH-1:0] htn; logic [31:0] sc; logic [31:0] bc;
  } exp_t;

  ent_t        chain[$];   // chain[k] = instruction currently k+1 edges into the chain
  exp_t        exp_q[$];
  logic [31:0] m_sc = 32'd0;
  logic [31:0] m_bc = 32'd0;
  logic [31:0] exp_stall4;

  function automatic ent_t zero_ent();
    ent_t e;
    e.v = 1'b0; e.rw = 1'b0; e.dst = 5'd0; e.tn = 0; e.pc = 32'd0; e.bd = 1'b0; e.exc = 5'd0; e.pl = '0;
    return e;
  endfunction

  // Tnew after (slot+1) cycles of ageing, floored at zero.
  function automatic int aged(int tn, int slot);
    int t;
    t = tn - (slot + 1);
    return (t < 0) ? 0 : t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_chain();
    chain.delete();
    for (int i = 0; i < DEPTH; i++) chain.push_back(zero_ent());
  endtask

  // Reference model step at a rising edge, then queue the expected visible state.
  task automatic model_edge();
    ent_t e;
    exp_t x;
    ent_t last;
    if (reset) begin
      clear_chain(); m_sc = 32'd0; m_bc = 32'd0;
    end else if (req) begin
      clear_chain();
    end else if (stall) begin
`ifdef STAGE_PERF_CNT_EN
      if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
`endif
    end else begin
      e = zero_ent();
      e.pc = in_pc; e.bd = in_bd;
      if (flush || !in_valid) begin
`ifdef STAGE_PERF_CNT_EN
        if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
`endif
      end else begin
        e.v = 1'b1; e.rw = in_regwrite; e.dst = in_dst; e.tn = int'(in_tnew);
        e.exc = (in_exc_code != 5'd0) ? in_exc_code : stage_exc_code;
        e.pl = in_payload;
      end
      chain.push_front(e);
      void'(chain.pop_back());
    end
    last  = chain[DEPTH-1];
    x.v   = last.v;  x.rw = last.rw; x.dst = last.dst; x.pc = last.pc; x.bd = last.bd;
    x.exc = last.exc; x.pl = last.pl; x.tn = TW'(aged(last.tn, DEPTH-1));
    x.hrw = '0; x.hdst = '0; x.htn = '0;
    for (int k = 0; k < DEPTH; k++) begin
      x.hrw[k]          = chain[k].v & chain[k].rw;
      x.hdst[5*k +: 5]  = chain[k].dst;
      x.htn[TW*k +: TW] = TW'(aged(chain[k].tn, k));
    end
    x.sc = m_sc; x.bc = m_bc;
    exp_q.push_back(x);
  endtask

  // Drive one cycle of inputs (from a falling edge), let the edge happen, update the model.
  task automatic step(input logic v, input logic rw, input logic [4:0] dst, input logic [TW-1:0] tn,
                      input logic [31:0] pc, input logic bd, input logic [4:0] ie, input logic [4:0] se,
                      input logic [PW-1:0] pl, input logic st, input logic fl, input logic rq);
    in_valid = v; in_regwrite = rw; in_dst = dst; in_tnew = tn; in_pc = pc; in_bd = bd;
    in_exc_code = ie; stage_exc_code = se; in_payload = pl; stall = st; flush = fl; req = rq;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, '0, 32'd0, 1'b0, 5'd0, 5'd0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rand_step();
    logic [4:0] ie;
    ie = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
    step(1'($urandom_range(0, 9) < 8), 1'($urandom), 5'($urandom), TW'($urandom), $urandom,
         1'($urandom), ie, 5'($urandom), {$urandom, $urandom},
         1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0));
  endtask

  // Monitor: compare the DUT's visible state with the queued expectation after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("out_valid", 64'(out_valid), 64'(x.v));
        chk("out_regwrite", 64'(out_regwrite), 64'(x.rw));
        chk("out_dst", 64'(out_dst), 64'(x.dst));
        chk("out_tnew", 64'(out_tnew), 64'(x.tn));
        chk("out_pc", 64'(out_pc), 64'(x.pc));
        chk("out_bd", 64'(out_bd), 64'(x.bd));
        chk("out_exc_code", 64'(out_exc_code), 64'(x.exc));
        chk("out_payload", out_payload, x.pl);
        chk("hz_regwrite", 64'(hz_regwrite), 64'(x.hrw));
        chk("hz_dst", 64'(hz_dst), 64'(x.hdst));
        chk("hz_tnew", 64'(hz_tnew), 64'(x.htn));
        chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(x.sc));
        chk("perf_bubble_cnt", 64'(perf_bubble_cnt), 64'(x.bc));
      end
    end
  end

  initial begin
    @(negedge clk);
    idle(); idle();
    reset = 1'b0;

    // Single instruction traverses three slots; Tnew ages 2 -> 1 -> 0 -> 0.
    step(1'b1, 1'b1, 5'd5, 2'd2, 32'h3000, 1'b0, 5'd0, 5'd0, 64'hA5A5, 1'b0, 1'b0, 1'b0);
    chk("t1_hz_tnew_slot0", 64'(hz_tnew), 64'h1);
    chk("t1_hz_regwrite", 64'(hz_regwrite), 64'h1);
    idle(); idle();
    chk("t1_out_valid", 64'(out_valid), 64'h1);
    chk("t1_out_pc", 64'(out_pc), 64'h3000);
    chk("t1_out_tnew", 64'(out_tnew), 64'h0);

    // Flush keeps PC/BD in the bubble.
    step(1'b1, 1'b1, 5'd9, 2'd3, 32'h3008, 1'b1, 5'd0, 5'd0, 64'h1, 1'b0, 1'b1, 1'b0);
    chk("t2_hz_regwrite0", 64'(hz_regwrite[0]), 64'h0);
    idle(); idle();
    chk("t2_out_valid", 64'(out_valid), 64'h0);
    chk("t2_out_pc", 64'(out_pc), 64'h3008);
    chk("t2_out_bd", 64'(out_bd), 64'h1);

    // Stall for four cycles mid-stream (flush also raised to show stall wins).
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 5'(i + 1), 2'd3, 32'h4000 + 32'(4 * i), 1'b0, 5'd0, 5'd0, 64'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 5'd31, 2'd0, 32'hDEAD, 1'b1, 5'd3, 5'd3, '1, 1'b1, 1'b1, 1'b0);
`ifdef STAGE_PERF_CNT_EN
    exp_stall4 = 32'd4;
`else
    exp_stall4 = 32'd0;
`endif
    chk("t3_perf_stall_cnt", 64'(perf_stall_cnt), 64'(exp_stall4));
    chk("t3_out_pc_held", 64'(out_pc), 64'h4000);

    // Request beats stall: everything clears.
    step(1'b1, 1'b1, 5'd7, 2'd1, 32'h5000, 1'b1, 5'd0, 5'd0, 64'h7, 1'b1, 1'b0, 1'b1);
    chk("t4_out_pc", 64'(out_pc), 64'h0);
    chk("t4_hz_dst", 64'(hz_dst), 64'h0);

    // Exception merge: upstream code wins, else the stage code.
    step(1'b1, 1'b1, 5'd2, 2'd1, 32'h6000, 1'b0, 5'd4, 5'd12, 64'h2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd3, 2'd1, 32'h6004, 1'b0, 5'd0, 5'd12, 64'h3, 1'b0, 1'b0, 1'b0);
    idle();
    chk("t5_exc_first", 64'(out_exc_code), 64'd4);
    idle();
    chk("t5_exc_second", 64'(out_exc_code), 64'd12);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) rand_step();

    // Asynchronous reset between edges while instructions are in flight.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 5'd17, 2'd3, 32'h7000 + 32'(4 * i), 1'b1, 5'd0, 5'd0, 64'h55, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'h0);
    chk("t6_out_pc", 64'(out_pc), 64'h0);
    chk("t6_hz_regwrite", 64'(hz_regwrite), 64'h0);
    chk("t6_perf_stall", 64'(perf_stall_cnt), 64'h0);
    chk("t6_perf_bubble", 64'(perf_bubble_cnt), 64'h0);
    idle();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) rand_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
